// File: rtl/aes_block_loader_pkg.sv
// Shared AES type and constant definitions used by the block loader and the
// downstream cipher pipeline.
package AESDefinitions;

    localparam int NUM_ROUNDS = 10;

    typedef logic [127:0] state_t;
    typedef logic [127:0] key_t;

    localparam int WORD_COUNT = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        ISSUE   = 1'b1
    } loader_state_e;

endpackage

// File: rtl/aes_block_loader_valid_delay.sv
// Fixed-depth shift register that reproduces its input strobe DEPTH cycles later.
module ValidDelay #(
    parameter int DEPTH = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic in_valid,
    output logic out_valid
);

    logic [DEPTH-1:0] taps;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            taps <= '0;
        end else begin
            taps[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign out_valid = taps[DEPTH-1];

endmodule

// File: rtl/aes_block_loader.sv
// Gathers 32-bit key and plaintext words into 128-bit groups and issues each
// completed plaintext block, with the committed key, to the cipher pipeline.
module aes_block_loader
    import AESDefinitions::*;
#(
    parameter int LATENCY = NUM_ROUNDS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_is_key,
    output state_t      block_out,
    output key_t        key_out,
    output logic        block_valid,
    output logic        result_valid
);

    localparam logic [1:0] LAST_WORD = 2'(WORD_COUNT - 1);

    loader_state_e state, next_state;

    logic [WORD_COUNT-1:0][31:0] kbuf;
    logic [WORD_COUNT-1:0][31:0] dbuf;
    logic [1:0]                  kcnt;
    logic [1:0]                  dcnt;
    logic                        take;

    // s_ready is gated by reset so it stays low while reset is held.
    assign s_ready     = (state == COLLECT) && !reset;
    assign block_valid = (state == ISSUE);
    assign take        = s_valid && s_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            COLLECT: begin
                if (take && !s_is_key && (dcnt == LAST_WORD)) begin
                    next_state = ISSUE;
                end
            end
            ISSUE:   next_state = COLLECT;
            default: next_state = COLLECT;
        endcase
    end

    // Word 0 of each group lands in the most significant 32 bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            kbuf      <= '0;
            dbuf      <= '0;
            kcnt      <= '0;
            dcnt      <= '0;
            key_out   <= '0;
            block_out <= '0;
        end else if (take) begin
            if (s_is_key) begin
                kbuf[kcnt] <= s_data;
                kcnt       <= kcnt + 2'd1;
                if (kcnt == LAST_WORD) begin
                    key_out <= {kbuf[0], kbuf[1], kbuf[2], s_data};
                end
            end else begin
                dbuf[dcnt] <= s_data;
                dcnt       <= dcnt + 2'd1;
                if (dcnt == LAST_WORD) begin
                    block_out <= {dbuf[0], dbuf[1], dbuf[2], s_data};
                end
            end
        end
    end

    ValidDelay #(
        .DEPTH(LATENCY)
    ) u_valid_delay (
        .clock    (clock),
        .reset    (reset),
        .in_valid (block_valid),
        .out_valid(result_valid)
    );

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed self-checking bench for aes_block_loader using hand-computed vectors.
module tb_aes_block_loader;
    import AESDefinitions::*;

    localparam int LAT = NUM_ROUNDS;

    logic        clock = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_is_key;
    state_t      block_out;
    key_t        key_out;
    logic        block_valid;
    logic        result_valid;

    int vectors      = 0;
    int miscompares  = 0;
    int issue_count  = 0;
    int result_count = 0;

    aes_block_loader #(
        .LATENCY(LAT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_is_key    (s_is_key),
        .block_out   (block_out),
        .key_out     (key_out),
        .block_valid (block_valid),
        .result_valid(result_valid)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (block_valid)  issue_count++;
        if (result_valid) result_count++;
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Presents one word and returns #1 after the edge that accepted it.
    task automatic applyStimulus(input logic is_key, input logic [31:0] data);
        int tries = 0;
        s_is_key = is_key;
        s_data   = data;
        s_valid  = 1'b1;
        while (s_ready !== 1'b1 && tries < 8) begin
            @(posedge clock);
            #1;
            tries++;
        end
        if (tries >= 8) begin
            checkOutput("ready_timeout", 128'(s_ready), 128'(1));
        end else begin
            @(posedge clock);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_s_ready"},      128'(s_ready),      128'(0));
        checkOutput({tag, "_block_valid"},  128'(block_valid),  128'(0));
        checkOutput({tag, "_result_valid"}, 128'(result_valid), 128'(0));
        checkOutput({tag, "_block_out"},    block_out,          128'(0));
        checkOutput({tag, "_key_out"},      key_out,            128'(0));
    endtask

    function automatic logic [127:0] streamBlock(input int b);
        logic [31:0] w0, w1, w2, w3;
        w0 = 32'h5000_0000 + 32'(4 * b);
        w1 = w0 + 32'd1;
        w2 = w0 + 32'd2;
        w3 = w0 + 32'd3;
        return {w0, w1, w2, w3};
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0]  key1 [4];
        logic [31:0]  pt1  [4];
        logic [31:0]  key2 [4];
        logic [31:0]  pt2  [4];
        logic [31:0]  pt3  [4];
        logic [127:0] key1_flat, pt1_flat, key2_flat, pt2_flat, pt3_flat;
        int           base_count, idx;
        logic         exp_bit;

        key1 = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
        pt1  = '{32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734};
        key2 = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
        pt2  = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
        pt3  = '{32'ha0a1a2a3, 32'hb0b1b2b3, 32'hc0c1c2c3, 32'hd0d1d2d3};
        key1_flat = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        pt1_flat  = 128'h3243f6a8885a308d313198a2e0370734;
        key2_flat = 128'h000102030405060708090a0b0c0d0e0f;
        pt2_flat  = 128'h00112233445566778899aabbccddeeff;
        pt3_flat  = 128'ha0a1a2a3b0b1b2b3c0c1c2c3d0d1d2d3;

        s_valid  = 1'b0;
        s_data   = '0;
        s_is_key = 1'b0;
        reset    = 1'b1;
        @(posedge clock);
        #1;
        checkAllZero("reset0");
        reset = 1'b0;
        #1;
        checkOutput("reset0_ready_rise", 128'(s_ready), 128'(1));

        // FIPS-197 key and plaintext, one group each.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, key1[i]);
        checkOutput("s1_key_out", key_out, key1_flat);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, pt1[i]);
            if (i < 3) checkOutput("s1_early_valid", 128'(block_valid), 128'(0));
        end
        checkOutput("s1_block_valid", 128'(block_valid), 128'(1));
        checkOutput("s1_ready_issue", 128'(s_ready), 128'(0));
        checkOutput("s1_block_out", block_out, pt1_flat);
        checkOutput("s1_key_at_issue", key_out, key1_flat);
        for (int i = 1; i <= LAT; i++) begin
            tick(1);
            if (i == 1) begin
                checkOutput("s1_valid_drop", 128'(block_valid), 128'(0));
                checkOutput("s1_ready_back", 128'(s_ready), 128'(1));
            end
            checkOutput("s1_result_valid", 128'(result_valid), 128'(i == LAT));
        end

        // Interleaved key and data words.
        base_count = issue_count;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, key2[i]);
            if (i == 2) checkOutput("s2_key_partial", key_out, key1_flat);
            if (i == 3) checkOutput("s2_key_out", key_out, key2_flat);
            applyStimulus(1'b0, pt2[i]);
            if (i < 3) checkOutput("s2_early_valid", 128'(block_valid), 128'(0));
        end
        checkOutput("s2_block_valid", 128'(block_valid), 128'(1));
        checkOutput("s2_block_out", block_out, pt2_flat);
        checkOutput("s2_key_at_issue", key_out, key2_flat);
        tick(2);
        checkOutput("s2_issue_count", 128'(issue_count - base_count), 128'(1));

        // Half a new key, then a full block: the block must use the old key.
        applyStimulus(1'b1, 32'hdeadbeef);
        applyStimulus(1'b1, 32'hcafebabe);
        checkOutput("s3_key_hold", key_out, key2_flat);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, pt3[i]);
        checkOutput("s3_block_valid", 128'(block_valid), 128'(1));
        checkOutput("s3_block_out", block_out, pt3_flat);
        checkOutput("s3_old_key", key_out, key2_flat);
        applyStimulus(1'b1, 32'h01234567);
        applyStimulus(1'b1, 32'h89abcdef);
        checkOutput("s3_new_key", key_out, 128'hdeadbeefcafebabe0123456789abcdef);

        // Continuous s_valid for three blocks.
        tick(LAT + 2);
        base_count = result_count;
        idx        = 0;
        s_is_key   = 1'b0;
        for (int c = 0; c < 14 + LAT + 2; c++) begin
            s_valid = (idx < 12);
            s_data  = 32'h5000_0000 + 32'(idx);
            checkOutput("s4_ready", 128'(s_ready), 128'(!((c % 5 == 4) && c <= 14)));
            if (s_valid && s_ready) idx++;
            @(posedge clock);
            #1;
            exp_bit = (c % 5 == 3) && (c < 14);
            checkOutput("s4_block_valid", 128'(block_valid), 128'(exp_bit));
            if (exp_bit) checkOutput("s4_block_out", block_out, streamBlock((c - 3) / 5));
            exp_bit = (c >= LAT + 3) && ((c - LAT - 3) % 5 == 0) && ((c - LAT - 3) / 5 < 3);
            checkOutput("s4_result_valid", 128'(result_valid), 128'(exp_bit));
        end
        s_valid = 1'b0;
        checkOutput("s4_result_count", 128'(result_count - base_count), 128'(3));

        // Reset in the middle of a data group.
        applyStimulus(1'b0, 32'h11111111);
        applyStimulus(1'b0, 32'h22222222);
        reset = 1'b1;
        #1;
        checkAllZero("s5_reset_mid");
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("s5_ready_rise", 128'(s_ready), 128'(1));
        applyStimulus(1'b0, 32'h33333333);
        applyStimulus(1'b0, 32'h44444444);
        checkOutput("s5_partial_dropped", 128'(block_valid), 128'(0));
        applyStimulus(1'b0, 32'h55555555);
        applyStimulus(1'b0, 32'h66666666);
        checkOutput("s5_fresh_valid", 128'(block_valid), 128'(1));
        checkOutput("s5_fresh_block", block_out, 128'h33333333444444445555555566666666);
        checkOutput("s5_key_cleared", key_out, 128'(0));

        // Reset with two blocks in flight.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h77777770 + 32'(i));
        checkOutput("s6_second_valid", 128'(block_valid), 128'(1));
        base_count = result_count;
        reset = 1'b1;
        #1;
        checkAllZero("s6_reset_flight");
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick(LAT + 5);
        checkOutput("s6_no_result", 128'(result_count - base_count), 128'(0));
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h99999990 + 32'(i));
        checkOutput("s6_fresh_valid", 128'(block_valid), 128'(1));
        checkOutput("s6_fresh_block", block_out, 128'h99999990999999919999999299999993);
        for (int i = 1; i <= LAT; i++) begin
            tick(1);
            checkOutput("s6_result_valid", 128'(result_valid), 128'(i == LAT));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_block_loader.md
AES_BLOCK_LOADER -- requirements
Module: aes_block_loader

Interface
REQ-001 Parameter LATENCY, default `NUM_ROUNDS, cycles from block issue to cipher output.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 s_valid  input  1  upstream word valid.
REQ-005 s_ready  output  1  loader accepts word this cycle.
REQ-006 s_data  input  32  key or plaintext word.
REQ-007 s_is_key  input  1  1 = s_data is a key word, 0 = plaintext word.
REQ-008 block_out  output  state_t (128)  assembled block, wired to the cipher pipeline input.
REQ-009 key_out  output  key_t (128)  committed key, wired to the cipher pipeline key input.
REQ-010 block_valid  output  1  one-cycle strobe marking the cycle block_out/key_out are a new issue.
REQ-011 result_valid  output  1  high in the cycle the cipher output corresponds to an issued block.

Function
REQ-012 A word transfers when s_valid and s_ready are both high at a rising edge; no other cycle changes any buffer.
REQ-013 Word n (0..3) of a group occupies bits [127-32n : 96-32n] of the 128-bit flattened value, so word 0 is most significant.
REQ-014 Key words fill a 4-word shadow key buffer via 2-bit counter kcnt; the 4th key word copies the completed buffer to key_out in the same edge and wraps kcnt to 0.
REQ-015 An incomplete key group never alters key_out.
REQ-016 Data words fill a 4-word data buffer via 2-bit counter dcnt; the 4th data word moves the FSM to ISSUE and wraps dcnt to 0.
REQ-017 FSM states: COLLECT (s_ready = 1) and ISSUE (s_ready = 0, block_valid = 1); ISSUE always returns to COLLECT after exactly one cycle.
REQ-018 On entry to ISSUE, block_out shall take the completed data buffer; block_out and key_out hold their values at all other times.
REQ-019 Key and data words may interleave arbitrarily; each counter advances only on words of its own kind.
REQ-020 If the 4th key word and the 4th data word complete on the same edge, which cannot happen because only one word transfers per cycle, no arbitration logic is required.
REQ-021 A key completing in the same edge as a data group's 4th word cannot occur; a key completing during the ISSUE cycle cannot occur (s_ready = 0).
REQ-022 The issued block uses the key_out value present during the ISSUE cycle.
REQ-023 result_valid shall be block_valid delayed by exactly LATENCY cycles through a LATENCY-deep shift register, which shifts every cycle.
REQ-024 Maximum throughput is one block per 5 cycles.

Reset
REQ-025 Asserting reset returns the FSM to COLLECT, clears kcnt, dcnt, both buffers, block_out, key_out and the valid shift register to 0.
REQ-026 Outputs under reset: s_ready = 0, block_valid = 0, result_valid = 0; s_ready rises in the first cycle after deassertion.
REQ-027 Reset mid-group discards partial key/data words.
REQ-028 Reset with blocks in flight discards their result_valid pulses.

Structure
REQ-029 state_t, key_t and `NUM_ROUNDS come from the shared AESDefinitions package.
REQ-030 A word-count constant (4) and the FSM state enum shall be added to AESDefinitions.
REQ-031 The LATENCY-deep valid delay is a sub-module named ValidDelay, parameterized by depth.

Verification
REQ-032 The bench shall send key words 0x2b7e1516, 0x28aed2a6, 0xabf71588, 0x09cf4f3c, then plaintext words 0x3243f6a8, 0x885a308d, 0x313198a2, 0xe0370734; it shall check block_valid one cycle after the last word, block_out = 0x3243f6a8885a308d313198a2e0370734, key_out = 0x2b7e151628aed2a6abf7158809cf4f3c, and result_valid exactly LATENCY cycles later.
REQ-033 The bench shall interleave key and data words (K,D,K,D,...); it shall check that each completed group lands correctly and that one issue occurs.
REQ-034 The bench shall send 2 of 4 new key words, then a full data group; it shall check that the issue uses the old key_out and that the key completes correctly afterwards.
REQ-035 The bench shall hold s_valid high continuously for 3 blocks; it shall check s_ready = 0 exactly in each ISSUE cycle, block spacing of 5 cycles, and 3 result_valid pulses spaced 5 cycles apart.
REQ-036 The bench shall assert reset after 2 data words and again with 2 blocks in flight; it shall check that all outputs are 0, that no result_valid appears, and that a fresh 4-word group issues correctly.
